// File: rtl/list_length_walker.sv
// Walks a linked list in data memory from a head pointer, streaming each node pointer and counting nodes.
// Optional macro LIST_WALK_PREV_CHECK_EN adds a back-pointer consistency check on every non-head node.
module list_length_walker #(
    parameter int WORD_SIZE   = 24,
    parameter int LEN_WIDTH   = 16,
    parameter int NEXT_OFFSET = 0,
    parameter int PREV_OFFSET = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [WORD_SIZE-1:0] i_head_ptr,
    output logic                 o_mem_rd_en,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    input  logic                 i_mem_rd_valid,
    input  logic [WORD_SIZE-1:0] i_mem_rd_data,
    output logic [WORD_SIZE-1:0] o_pc,
    output logic                 o_pc_valid,
    output logic [LEN_WIDTH-1:0] o_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ_NEXT  = 3'd1,
        S_WAIT_NEXT = 3'd2,
`ifdef LIST_WALK_PREV_CHECK_EN
        S_REQ_PREV  = 3'd3,
        S_WAIT_PREV = 3'd4,
`endif
        S_DONE      = 3'd5
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;
    localparam logic [WORD_SIZE-1:0] NEXT_OFF = WORD_SIZE'(NEXT_OFFSET);
    localparam logic [WORD_SIZE-1:0] PREV_OFF = WORD_SIZE'(PREV_OFFSET);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [LEN_WIDTH-1:0] length_q, length_d;
    logic                 pc_valid_q, pc_valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 rd_prev_field;
`ifdef LIST_WALK_PREV_CHECK_EN
    logic [WORD_SIZE-1:0] prev_ptr_q, prev_ptr_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        length_d      = length_q;
        pc_valid_d    = 1'b0;
        busy_d        = busy_q;
        err_d         = err_q;
        rd_prev_field = 1'b0;
        o_mem_rd_en   = 1'b0;
        o_mem_addr    = '0;
        o_done        = 1'b0;
`ifdef LIST_WALK_PREV_CHECK_EN
        prev_ptr_d    = prev_ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    pc_d       = i_head_ptr;
                    pc_valid_d = 1'b1;
                    length_d   = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (i_head_ptr == '0) ? S_DONE : S_REQ_NEXT;
                end
            end
            S_REQ_NEXT: begin
                o_mem_rd_en = 1'b1;
                state_d     = S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (i_mem_rd_valid) begin
                    pc_d       = i_mem_rd_data;
                    pc_valid_d = 1'b1;
`ifdef LIST_WALK_PREV_CHECK_EN
                    prev_ptr_d = pc_q;
`endif
                    // A full counter means the list is too long or cyclic: saturate and stop.
                    if (length_q == LEN_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        length_d = length_q + LEN_WIDTH'(1);
                        if (i_mem_rd_data == '0) begin
                            state_d = S_DONE;
                        end else begin
`ifdef LIST_WALK_PREV_CHECK_EN
                            state_d = S_REQ_PREV;
`else
                            state_d = S_REQ_NEXT;
`endif
                        end
                    end
                end
            end
`ifdef LIST_WALK_PREV_CHECK_EN
            S_REQ_PREV: begin
                o_mem_rd_en   = 1'b1;
                rd_prev_field = 1'b1;
                state_d       = S_WAIT_PREV;
            end
            S_WAIT_PREV: begin
                if (i_mem_rd_valid) begin
                    if (i_mem_rd_data != prev_ptr_q) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ_NEXT;
                    end
                end
            end
`endif
            S_DONE: begin
                o_done  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (o_mem_rd_en) begin
            o_mem_addr = pc_q + (rd_prev_field ? PREV_OFF : NEXT_OFF);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            length_q   <= '0;
            pc_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LIST_WALK_PREV_CHECK_EN
            prev_ptr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            length_q   <= length_d;
            pc_valid_q <= pc_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef LIST_WALK_PREV_CHECK_EN
            prev_ptr_q <= prev_ptr_d;
`endif
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_valid = pc_valid_q;
    assign o_length   = length_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule
